// File: rtl/pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pulse_stretcher : stretches requests into active-low windows + gap.   |
// | Optional queueing via PULSE_STRETCH_QUEUE_EN.          Rev 1.0        |
// +----------------------------------------------------------------------+
module pulse_stretcher #(
   parameter int ACTIVE_LEN = 8,
   parameter int GAP_LEN    = 4,
   parameter int PEND_DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       singlePulse,
   input  logic       clrOvf,
   output logic       longPulse,
   output logic       busy,
   output logic [1:0] pendCount,
   output logic       overflow
);

   localparam int CNT_MAX = (ACTIVE_LEN > GAP_LEN) ? ACTIVE_LEN : GAP_LEN;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] c_act_load = CNT_W'(ACTIVE_LEN - 1);
   localparam logic [CNT_W-1:0] c_gap_load = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [1:0]       c_pend_cap = 2'(PEND_DEPTH);

   if (ACTIVE_LEN < 1 || GAP_LEN < 1 || PEND_DEPTH < 1 || PEND_DEPTH > 3) begin : g_bad_params
      $error("pulse_stretcher: parameter out of legal range");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GAP    = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;

   logic w_last_gap;
   logic w_enq;
   logic w_accept;
   logic w_drop;
   logic w_dequeue;
   logic w_full;

   // The final GAP cycle is handled as a hand-off point, not as a queue slot.
   assign w_last_gap = (r_state == S_GAP) && (r_cnt == '0);
   assign w_enq      = singlePulse && (r_state != S_IDLE) && !w_last_gap;
   assign w_full     = (pendCount >= c_pend_cap);

`ifdef PULSE_STRETCH_QUEUE_EN
   assign w_accept   = w_enq && !w_full;
`else
   assign w_accept   = 1'b0 & w_full;
`endif

   assign w_drop     = w_enq && !w_accept;
   assign w_dequeue  = w_last_gap && (pendCount != 2'd0) && !singlePulse;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         longPulse <= 1'b1;
         busy      <= 1'b0;
         pendCount <= 2'd0;
         overflow  <= 1'b0;
      end else begin
         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop) begin
            overflow <= 1'b1;
         end else if (clrOvf) begin
            overflow <= 1'b0;
         end

         if (w_accept) begin
            pendCount <= pendCount + 2'd1;
         end else if (w_dequeue) begin
            pendCount <= pendCount - 2'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (singlePulse) begin
                  r_state   <= S_ACTIVE;
                  r_cnt     <= c_act_load;
                  longPulse <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_ACTIVE: begin
               if (r_cnt == '0) begin
                  r_state   <= S_GAP;
                  r_cnt     <= c_gap_load;
                  longPulse <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - c_cnt_one;
               end
            end
            S_GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_cnt_one;
               end else if ((pendCount != 2'd0) || singlePulse) begin
                  r_state   <= S_ACTIVE;
                  r_cnt     <= c_act_load;
                  longPulse <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_cnt     <= '0;
               longPulse <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pulse_stretcher : directed self-checking bench for pulse_stretcher |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       singlePulse = 1'b0;
   logic       clrOvf = 1'b0;
   logic       longPulse;
   logic       busy;
   logic [1:0] pendCount;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef PULSE_STRETCH_QUEUE_EN
   localparam logic [1:0] EXP_MID_PEND = 2'd2;
   localparam logic       EXP_MID_OVF  = 1'b0;
`else
   localparam logic [1:0] EXP_MID_PEND = 2'd0;
   localparam logic       EXP_MID_OVF  = 1'b1;
`endif

   always #5 clk = ~clk;

   pulse_stretcher #(
      .ACTIVE_LEN (8),
      .GAP_LEN    (4),
      .PEND_DEPTH (3)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .singlePulse (singlePulse),
      .clrOvf      (clrOvf),
      .longPulse   (longPulse),
      .busy        (busy),
      .pendCount   (pendCount),
      .overflow    (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vectors below are {longPulse, busy, pendCount[1:0], overflow}.
   task automatic test_reset();
      logic [4:0] got;
      singlePulse = 1'b0;
      clrOvf      = 1'b0;
      #1 rst = 1'b0;
      #1;
      got = {longPulse, busy, pendCount, overflow};
      n_checks++;
      if (got !== 5'b10000) $display("FAIL reset_pre_clk got=%b exp=%b", got, 5'b10000);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== 5'b10000) $display("FAIL reset_held cyc=%0d got=%b exp=%b", i, got, 5'b10000);
         else n_pass++;
      end
      rst = 1'b1;
   endtask

   task automatic test_single_pulse();
      logic [4:0] got, exp;
      for (int c = 0; c <= 16; c++) begin
         singlePulse = (c == 0);
         exp = {!(c >= 1 && c <= 8), (c >= 1 && c <= 12), 2'd0, 1'b0};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL single_pulse cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         tick();
      end
      singlePulse = 1'b0;
   endtask

   // Request on the final GAP cycle restarts immediately with no IDLE cycle.
   task automatic test_back_to_back();
      logic [4:0] got, exp;
      for (int c = 0; c <= 27; c++) begin
         singlePulse = (c == 0) || (c == 12);
         exp = {!((c >= 1 && c <= 8) || (c >= 13 && c <= 20)), (c >= 1 && c <= 24), 2'd0, 1'b0};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         tick();
      end
      singlePulse = 1'b0;
   endtask

`ifdef PULSE_STRETCH_QUEUE_EN
   task automatic test_queue_one();
      logic [4:0] got, exp;
      logic [1:0] ep;
      for (int c = 0; c <= 27; c++) begin
         singlePulse = (c == 0) || (c == 3);
         ep  = (c >= 4 && c <= 12) ? 2'd1 : 2'd0;
         exp = {!((c >= 1 && c <= 8) || (c >= 13 && c <= 20)), (c >= 1 && c <= 24), ep, 1'b0};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL queue_one cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         tick();
      end
      singlePulse = 1'b0;
   endtask

   // Clear coincides with the dropping request at cycle 5: the set must win.
   task automatic test_saturate();
      logic [4:0] got, exp;
      logic [1:0] ep;
      logic       el;
      logic       prev_long;
      int         windows;
      windows   = 0;
      prev_long = 1'b1;
      for (int c = 0; c <= 52; c++) begin
         singlePulse = (c == 0) || (c >= 2 && c <= 5);
         clrOvf      = (c == 5) || (c == 30);
         if      (c == 3)             ep = 2'd1;
         else if (c == 4)             ep = 2'd2;
         else if (c >= 5 && c <= 12)  ep = 2'd3;
         else if (c >= 13 && c <= 24) ep = 2'd2;
         else if (c >= 25 && c <= 36) ep = 2'd1;
         else                         ep = 2'd0;
         el  = !((c >= 1 && c <= 8) || (c >= 13 && c <= 20) ||
                 (c >= 25 && c <= 32) || (c >= 37 && c <= 44));
         exp = {el, (c >= 1 && c <= 48), ep, (c >= 6 && c <= 30)};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL saturate cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         if (prev_long === 1'b1 && longPulse === 1'b0) windows++;
         prev_long = longPulse;
         tick();
      end
      singlePulse = 1'b0;
      clrOvf      = 1'b0;
      n_checks++;
      if (windows !== 4) $display("FAIL saturate_windows got=%0d exp=%0d", windows, 4);
      else n_pass++;
   endtask
`else
   task automatic test_drop_no_queue();
      logic [4:0] got, exp;
      for (int c = 0; c <= 16; c++) begin
         singlePulse = (c == 0) || (c == 5);
         exp = {!(c >= 1 && c <= 8), (c >= 1 && c <= 12), 2'd0, (c >= 6)};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL drop_no_queue cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         tick();
      end
      singlePulse = 1'b0;
   endtask

   // Enters with overflow still set from the previous task.
   task automatic test_ovf_priority();
      logic [4:0] got, exp;
      for (int c = 0; c <= 16; c++) begin
         singlePulse = (c == 2) || (c == 5);
         clrOvf      = (c == 0) || (c == 5) || (c == 8);
         exp = {!(c >= 3 && c <= 10), (c >= 3 && c <= 14), 2'd0, (c == 0) || (c >= 6 && c <= 8)};
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== exp) $display("FAIL ovf_priority cyc=%0d got=%b exp=%b", c, got, exp);
         else n_pass++;
         tick();
      end
      singlePulse = 1'b0;
      clrOvf      = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      logic [4:0] got, exp;
      for (int c = 0; c <= 3; c++) begin
         singlePulse = (c <= 2);
         tick();
      end
      singlePulse = 1'b0;
      exp = {1'b0, 1'b1, EXP_MID_PEND, EXP_MID_OVF};
      got = {longPulse, busy, pendCount, overflow};
      n_checks++;
      if (got !== exp) $display("FAIL reset_mid_pre got=%b exp=%b", got, exp);
      else n_pass++;
      rst = 1'b0;
      #1;
      got = {longPulse, busy, pendCount, overflow};
      n_checks++;
      if (got !== 5'b10000) $display("FAIL reset_mid_abort got=%b exp=%b", got, 5'b10000);
      else n_pass++;
      tick();
      tick();
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         got = {longPulse, busy, pendCount, overflow};
         n_checks++;
         if (got !== 5'b10000) $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", c, got, 5'b10000);
         else n_pass++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_back_to_back();
`ifdef PULSE_STRETCH_QUEUE_EN
      test_queue_one();
      test_saturate();
`else
      test_drop_no_queue();
      test_ovf_priority();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter ACTIVE_LEN, default 8: cycles longPulse is held asserted (low) per pulse, legal range >=1.
REQ-002 Parameter GAP_LEN, default 4: minimum deasserted (high) cycles after each active window, legal range >=1.
REQ-003 Parameter PEND_DEPTH, default 3: maximum queued requests, legal range 1..3.
REQ-004 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on the rising edge.
REQ-005 The port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-006 The port singlePulse SHALL be an input, 1 bit wide, and is the request; it is sampled high on a rising edge.
REQ-007 The port clrOvf SHALL be an input, 1 bit wide, and is a synchronous clear of overflow.
REQ-008 The port longPulse SHALL be a registered output, 1 bit wide, and is the stretched pulse, active-low (idle 1).
REQ-009 The port busy SHALL be a registered output, 1 bit wide, and is 1 whenever the state is not IDLE.
REQ-010 The port pendCount SHALL be a registered output, 2 bits wide, and is the number of queued requests.
REQ-011 The port overflow SHALL be a registered output, 1 bit wide, and is a sticky flag indicating that a request was dropped.

Function
REQ-012 The FSM SHALL have the states IDLE, ACTIVE and GAP, with a down-counter sized to max(ACTIVE_LEN, GAP_LEN).
REQ-013 When the state is IDLE and singlePulse=1 on edge N, the block SHALL enter ACTIVE, and longPulse SHALL be 0 for cycles N+1..N+ACTIVE_LEN.
REQ-014 After ACTIVE_LEN cycles in ACTIVE, the block SHALL enter GAP, with longPulse=1 for exactly GAP_LEN cycles.
REQ-015 At the end of GAP, if pendCount>0, the block SHALL enter ACTIVE directly, decrement pendCount, and insert no IDLE cycle.
REQ-016 At the end of GAP, if pendCount=0 and singlePulse=0, the block SHALL enter IDLE.
REQ-017 At the end of GAP, if pendCount=0 and singlePulse=1, the block SHALL enter ACTIVE, and pendCount SHALL be unchanged.
REQ-018 When singlePulse=1 in ACTIVE or GAP, excluding the final GAP cycle with pendCount=0, the request SHALL be queued.
REQ-019 A queued request SHALL increment pendCount if pendCount<PEND_DEPTH; otherwise it is dropped and overflow is set to 1.
REQ-020 When singlePulse=1 and a dequeue occur in the same final GAP cycle, pendCount SHALL be net unchanged and the block SHALL enter ACTIVE.
REQ-021 A singlePulse held high for K consecutive cycles SHALL count as K requests, with no edge detection.
REQ-022 pendCount SHALL never exceed PEND_DEPTH and SHALL never wrap below 0.
REQ-023 overflow SHALL remain 1 until clrOvf=1 or reset.
REQ-024 If clrOvf=1 and a drop occur in the same cycle, overflow SHALL be 1, with the set winning.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force state=IDLE, counter=0, longPulse=1, busy=0, pendCount=0 and overflow=0.
REQ-026 A reset asserted mid-ACTIVE or mid-GAP SHALL abort the window immediately, discard queued requests, and produce no residual pulse after release.
REQ-027 After rst rises, the first request sampled SHALL behave exactly per REQ-013.

Configuration
REQ-028 The macro PULSE_STRETCH_QUEUE_EN, when defined, SHALL enable the REQ-018..REQ-020 queue behaviour.
REQ-029 When PULSE_STRETCH_QUEUE_EN is undefined, every request arriving outside IDLE (except per REQ-017) SHALL be dropped and set overflow, pendCount SHALL be held at 0, and REQ-015 never fires.

Verification
REQ-030 Scenario: rst=0 for 3 cycles -> longPulse=1, busy=0, pendCount=0, overflow=0, including the cycles before any clk edge.
REQ-031 Scenario: single singlePulse at cycle 0 -> longPulse=0 in cycles 1..8, longPulse=1 from cycle 9, busy=1 in cycles 1..12, IDLE at cycle 13.
REQ-032 Scenario: pulses at cycles 0 and 3 (queue enabled) -> pendCount=1 during cycles 4..12, second longPulse=0 in cycles 13..20, busy drops at cycle 25.
REQ-033 Scenario: 5 pulses at cycles 0,2,3,4,5 -> pendCount saturates at 3, overflow=1 from cycle 6, exactly 4 active windows, clrOvf at cycle 30 -> overflow=0 at cycle 31.
REQ-034 Scenario: rst=0 at cycle 4 of an active window with pendCount=2 -> longPulse=1 and pendCount=0 immediately, with no pulse after release.
REQ-035 Scenario: macro undefined, pulse at cycle 0 and pulse at cycle 5 -> one window only, overflow=1 from cycle 6, pendCount=0 throughout.
